data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 141 ++++++++++++++
 tb/tb_data_cache.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back / write-allocate data cache: 16 lines of 16 bytes
// between the CPU load/store port and a multi-cycle block memory.
module data_cache (
    input  logic         CLK,
    input  logic         RESET,
    output logic         BUSYWAIT,
    input  logic [2:0]   READ,
    input  logic [1:0]   WRITE,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    input  logic [31:0]  ADDRESS,
    input  logic         MEM_BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    input  logic [127:0] MEM_READDATA,
    output logic [127:0] MEM_WRITEDATA,
    output logic [27:0]  MEM_ADDRESS
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t       state;
    logic [127:0] data_arr [16];
    logic [23:0]  tag_arr  [16];
    logic [15:0]  valid_bits;
    logic [15:0]  dirty_bits;
    logic [127:0] fill_buf;

    logic [3:0]   index;
    logic [3:0]   offset;
    logic [23:0]  tag;
    logic         read_active;
    logic         write_active;
    logic         access_active;
    logic         hit;
    logic [127:0] cur_blk;
    logic [127:0] merged_blk;
    logic [31:0]  word_sel;
    logic [15:0]  half_sel;
    logic [7:0]   byte_sel;

    assign index  = ADDRESS[7:4];
    assign offset = ADDRESS[3:0];
    assign tag    = ADDRESS[31:8];

    assign read_active   = (READ == 3'b001) || (READ == 3'b010) || (READ == 3'b011) ||
                           (READ == 3'b101) || (READ == 3'b110);
    assign write_active  = (WRITE != 2'b00);
    assign access_active = read_active || write_active;
    assign hit           = valid_bits[index] && (tag_arr[index] == tag);
    assign cur_blk       = data_arr[index];

    assign word_sel = cur_blk[{offset[3:2], 5'd0} +: 32];
    assign half_sel = cur_blk[{offset[3:1], 4'd0} +: 16];
    assign byte_sel = cur_blk[{offset, 3'd0} +: 8];

    always_comb begin
        case (READ)
            3'b001:  READDATA = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  READDATA = {{16{half_sel[15]}}, half_sel};
            3'b011:  READDATA = word_sel;
            3'b101:  READDATA = {24'd0, byte_sel};
            3'b110:  READDATA = {16'd0, half_sel};
            default: READDATA = 32'd0;
        endcase
    end

    // Store data merged into the indexed block; only the addressed lanes change.
    always_comb begin
        merged_blk = cur_blk;
        case (WRITE)
            2'b01:   merged_blk[{offset, 3'd0} +: 8]        = WRITEDATA[7:0];
            2'b10:   merged_blk[{offset[3:1], 4'd0} +: 16]  = WRITEDATA[15:0];
            2'b11:   merged_blk[{offset[3:2], 5'd0} +: 32]  = WRITEDATA;
            default: merged_blk = cur_blk;
        endcase
    end

    assign BUSYWAIT      = (state != IDLE) || (access_active && !hit);
    assign MEM_WRITEDATA = cur_blk;
    assign MEM_ADDRESS   = (state == WRITEBACK) ? {tag_arr[index], index} : ADDRESS[31:4];

    // Block storage carries no reset; a line is only trusted through its valid bit.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data_arr[index] <= fill_buf;
            tag_arr[index]  <= tag;
        end else if (state == IDLE && write_active && hit) begin
            data_arr[index] <= merged_blk;
        end
        if (state == FETCH && !MEM_BUSYWAIT) begin
            fill_buf <= MEM_READDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            valid_bits <= '0;
            dirty_bits <= '0;
            MEM_READ   <= 1'b0;
            MEM_WRITE  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access_active) begin
                        if (hit) begin
                            if (write_active) begin
                                dirty_bits[index] <= 1'b1;
                            end
                        end else if (valid_bits[index] && dirty_bits[index]) begin
                            state     <= WRITEBACK;
                            MEM_WRITE <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            MEM_READ <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state     <= FETCH;
                        MEM_WRITE <= 1'b0;
                        MEM_READ  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state    <= UPDATE;
                        MEM_READ <= 1'b0;
                    end
                end
                UPDATE: begin
                    valid_bits[index] <= 1'b1;
                    dirty_bits[index] <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: a flat byte-memory model predicts load results and a
// line-occupancy model predicts stalls, write-backs and fills cycle by cycle.
module tb_data_cache;
    localparam int LAT       = 5;
    localparam int MEM_BYTES = 1024;

    logic         clock = 1'b0;
    logic         reset;
    logic         busywait;
    logic [2:0]   read_op;
    logic [1:0]   write_op;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic [31:0]  address;
    logic         mem_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_read_data;
    logic [127:0] mem_write_data;
    logic [27:0]  mem_address;

    always #5 clock = ~clock;

    data_cache dut (
        .CLK(clock), .RESET(reset), .BUSYWAIT(busywait), .READ(read_op), .WRITE(write_op),
        .WRITEDATA(write_data), .READDATA(read_data), .ADDRESS(address),
        .MEM_BUSYWAIT(mem_busywait), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
        .MEM_READDATA(mem_read_data), .MEM_WRITEDATA(mem_write_data), .MEM_ADDRESS(mem_address)
    );

    // Block memory: busy for LAT cycles once a request appears, completes on the drop.
    logic [7:0]   bmem [MEM_BYTES];
    int           mem_cnt;
    logic [27:0]  last_wb_addr;
    logic [127:0] last_wb_data;

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt < LAT);

    always_comb begin
        mem_read_data = '0;
        for (int k = 0; k < 16; k++) begin
            mem_read_data[8*k +: 8] = bmem[int'(mem_address[5:0]) * 16 + k];
        end
    end

    initial begin
        mem_cnt      = 0;
        last_wb_addr = '0;
        last_wb_data = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            bmem[i] = (i < 16) ? 8'h00 : 8'($urandom);
        end
        forever begin
            @(posedge clock);
            if (mem_read || mem_write) begin
                if (mem_busywait) begin
                    mem_cnt <= mem_cnt + 1;
                end else begin
                    mem_cnt <= 0;
                    if (mem_write) begin
                        for (int k = 0; k < 16; k++) begin
                            bmem[int'(mem_address[5:0]) * 16 + k] <= mem_write_data[8*k +: 8];
                        end
                        last_wb_addr <= mem_address;
                        last_wb_data <= mem_write_data;
                    end
                end
            end else begin
                mem_cnt <= 0;
            end
        end
    end

    // Architectural view: what every byte must read as, whether cached or not.
    logic [7:0] arch [MEM_BYTES];
    bit         mvalid [16];
    bit         mdirty [16];
    int         mtag   [16];

    int           checks;
    int           errors;
    logic         chk_en;
    logic         exp_busy, exp_mr, exp_mw, exp_wb_chk, exp_rd_chk;
    logic [27:0]  exp_maddr;
    logic [127:0] exp_wb;
    logic [31:0]  exp_rdata;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            checkOutput("busywait", {31'd0, busywait}, {31'd0, exp_busy});
            checkOutput("mem_read", {31'd0, mem_read}, {31'd0, exp_mr});
            checkOutput("mem_write", {31'd0, mem_write}, {31'd0, exp_mw});
            if (exp_mr || exp_mw) begin
                checkOutput("mem_address", {4'd0, mem_address}, {4'd0, exp_maddr});
            end
            if (exp_wb_chk) begin
                for (int w = 0; w < 4; w++) begin
                    checkOutput("mem_write_data", mem_write_data[32*w +: 32], exp_wb[32*w +: 32]);
                end
            end
            if (exp_rd_chk) begin
                checkOutput("read_data", read_data, exp_rdata);
            end
        end
    end

    function automatic logic [127:0] archBlock(input int blk);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = arch[blk * 16 + k];
        end
        return r;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] rd, input int addr);
        int hb;
        int wb;
        hb = addr & ~1;
        wb = addr & ~3;
        case (rd)
            3'b001:  return {{24{arch[addr][7]}}, arch[addr]};
            3'b010:  return {{16{arch[hb+1][7]}}, arch[hb+1], arch[hb]};
            3'b011:  return {arch[wb+3], arch[wb+2], arch[wb+1], arch[wb]};
            3'b101:  return {24'd0, arch[addr]};
            3'b110:  return {16'd0, arch[hb+1], arch[hb]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic setExp(input logic busy, input logic mr, input logic mw, input logic [27:0] maddr,
                          input logic wbc, input logic [127:0] wb, input logic rdc, input logic [31:0] rdata);
        exp_busy   = busy;
        exp_mr     = mr;
        exp_mw     = mw;
        exp_maddr  = maddr;
        exp_wb_chk = wbc;
        exp_wb     = wb;
        exp_rd_chk = rdc;
        exp_rdata  = rdata;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic resyncModel();
        for (int i = 0; i < MEM_BYTES; i++) arch[i] = bmem[i];
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
            mtag[i]   = 0;
        end
    endtask

    // One CPU access, held until the model says it completes; entered at posedge+1.
    task automatic applyStimulus(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] wd,
                                 input int addr, input bit has_lit, input logic [31:0] lit);
        int idx;
        int tg;
        int old_blk;
        bit is_rd;
        bit hit;
        idx   = (addr >> 4) & 15;
        tg    = addr >> 8;
        is_rd = rd inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
        read_op    = rd;
        write_op   = wr;
        write_data = wd;
        address    = 32'(addr);
        if (!is_rd && wr == 2'b00) begin
            setExp(0, 0, 0, '0, 0, '0, 0, '0);
            step();
            return;
        end
        hit = mvalid[idx] && (mtag[idx] == tg);
        if (!hit) begin
            setExp(1, 0, 0, '0, 0, '0, 0, '0);
            step();
            if (mvalid[idx] && mdirty[idx]) begin
                old_blk = (mtag[idx] << 4) | idx;
                for (int c = 0; c <= LAT; c++) begin
                    setExp(1, 0, 1, 28'(old_blk), 1, archBlock(old_blk), 0, '0);
                    step();
                end
            end
            for (int c = 0; c <= LAT; c++) begin
                setExp(1, 1, 0, 28'(addr >> 4), 0, '0, 0, '0);
                step();
            end
            setExp(1, 0, 0, '0, 0, '0, 0, '0);
            step();
            mvalid[idx] = 1;
            mtag[idx]   = tg;
            mdirty[idx] = 0;
        end
        setExp(0, 0, 0, '0, 0, '0, is_rd && (wr == 2'b00), expLoad(rd, addr));
        if (has_lit) begin
            @(negedge clock);
            #1;
            checkOutput("literal_read_data", read_data, lit);
        end
        step();
        case (wr)
            2'b01: arch[addr] = wd[7:0];
            2'b10: begin
                arch[addr & ~1]       = wd[7:0];
                arch[(addr & ~1) + 1] = wd[15:8];
            end
            2'b11: for (int k = 0; k < 4; k++) arch[(addr & ~3) + k] = wd[8*k +: 8];
            default: ;
        endcase
        if (wr != 2'b00) mdirty[idx] = 1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] rd;
        logic [1:0] wr;
        int         a;
        checks     = 0;
        errors     = 0;
        chk_en     = 0;
        reset      = 1;
        read_op    = '0;
        write_op   = '0;
        write_data = '0;
        address    = '0;
        setExp(0, 0, 0, '0, 0, '0, 0, '0);
        step();
        step();
        reset = 0;
        resyncModel();
        chk_en = 1;
        step();

        applyStimulus(3'b000, 2'b11, 32'hC0010003, 32'h0, 0, '0);
        applyStimulus(3'b011, 2'b00, '0, 32'h0, 1, 32'hC0010003);
        applyStimulus(3'b001, 2'b00, '0, 32'h3, 1, 32'hFFFFFFC0);
        applyStimulus(3'b101, 2'b00, '0, 32'h3, 1, 32'h000000C0);
        applyStimulus(3'b010, 2'b00, '0, 32'h2, 1, 32'hFFFFC001);
        applyStimulus(3'b110, 2'b00, '0, 32'h0, 1, 32'h00000003);
        applyStimulus(3'b000, 2'b01, 32'h000000AB, 32'h5, 0, '0);
        applyStimulus(3'b011, 2'b00, '0, 32'h4, 1, 32'h0000AB00);
        applyStimulus(3'b011, 2'b00, '0, 32'h100, 0, '0);
        checkOutput("evict_address", {4'd0, last_wb_addr}, 32'h0);
        checkOutput("evict_word0", last_wb_data[31:0], 32'hC0010003);
        applyStimulus(3'b011, 2'b00, '0, 32'h0, 1, 32'hC0010003);

        // Abort a fill two cycles into FETCH.
        read_op  = 3'b011;
        write_op = 2'b00;
        address  = 32'h200;
        setExp(1, 0, 0, '0, 0, '0, 0, '0);
        step();
        setExp(1, 1, 0, 28'h20, 0, '0, 0, '0);
        step();
        step();
        reset   = 1;
        read_op = 3'b000;
        step();
        reset = 0;
        setExp(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clock);
        #1;
        checkOutput("reset_mem_read", {31'd0, mem_read}, 32'd0);
        checkOutput("reset_busywait", {31'd0, busywait}, 32'd0);
        step();
        resyncModel();
        applyStimulus(3'b011, 2'b00, '0, 32'h0, 1, 32'hC0010003);

        for (int n = 0; n < 300; n++) begin
            a  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            wr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) wr = 2'b00;
            if (wr == 2'b00) begin
                case ($urandom_range(0, 4))
                    0:       rd = 3'b001;
                    1:       rd = 3'b010;
                    2:       rd = 3'b011;
                    3:       rd = 3'b101;
                    default: rd = 3'b110;
                endcase
            end else begin
                rd = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 15) == 0) begin
                rd = 3'b000;
                wr = 2'b00;
            end
            applyStimulus(rd, wr, $urandom, a, 0, '0);
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
